// File: rtl/boot_rom_pipe.sv
// boot_rom_pipe: pipelined boot ROM on the core's boot fetch port.
// Requests are granted while fewer than MAX_OUTST responses are owed. Each grant
// becomes a {valid, err, data} token that travels LATENCY stages, with the last
// stage being the response FIFO. Responses leave strictly in grant order.
//
// Handshake: a request transfers on a cycle where req_i && gnt_o. A response
// transfers on a cycle where rvalid_o && rready_i. While rvalid_o && !rready_i
// the head response (rdata_o/err_o) is held stable. rvalid_o depends only on
// registered state, so rready_i never feeds back into it combinationally.
module boot_rom_pipe #(
    parameter int                              DATA_WIDTH = 64,
    parameter int                              ADDR_WIDTH = 64,
    parameter int                              NUM_WORDS  = 8,
    parameter logic [ADDR_WIDTH-1:0]           BASE_ADDR  = ADDR_WIDTH'(64'h1000),
    parameter int                              LATENCY    = 1,
    parameter int                              MAX_OUTST  = 2,
    parameter logic [NUM_WORDS*DATA_WIDTH-1:0] ROM_INIT   = (NUM_WORDS*DATA_WIDTH)'({
        64'h00000000_00000000, 64'h00000000_00000000,
        64'h00000000_00000000, 64'h00000000_00000000,
        64'h00000000_80000000, 64'h00000000_00028067,
        64'h0182b283_f1402573, 64'h02028593_00000297})
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int OFF_SH         = $clog2(BYTES_PER_WORD);
    localparam int IDX_W          = $clog2(NUM_WORDS);
    localparam int CNT_W          = $clog2(MAX_OUTST + 1);
    localparam int PTR_W          = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [ADDR_WIDTH-1:0] ROM_BYTES = ADDR_WIDTH'(NUM_WORDS * BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(MAX_OUTST - 1);

    // ROM contents split into words, word 0 taken from the LSBs
    logic [DATA_WIDTH-1:0] rom_w [NUM_WORDS];
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_rom
        assign rom_w[i] = ROM_INIT[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Address decode in the grant cycle
    logic [ADDR_WIDTH-1:0] off;
    logic [IDX_W-1:0]      idx;
    logic                  hit;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] dec_data;

    // Decode: offset from base, in-range test, word index (sub-word bits dropped)
    always_comb begin
        off      = addr_i - BASE_ADDR;
        idx      = IDX_W'(off >> OFF_SH);
        hit      = (addr_i >= BASE_ADDR) && (off < ROM_BYTES);
        dec_err  = we_i || !hit;
        dec_data = dec_err ? '0 : rom_w[idx];
    end

    // Outstanding counter and FIFO state
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             pop;

    // The outstanding bound is what keeps the FIFO from ever overflowing
    assign gnt_o = req_i && (outst_q < MAX_CNT);
    assign pop   = rvalid_o && rready_i;

    // Token entering the FIFO: straight from decode, or from the last pipe stage
    logic                  push_v;
    logic                  push_err;
    logic [DATA_WIDTH-1:0] push_data;

    if (LATENCY == 1) begin : g_direct
        assign push_v    = gnt_o;
        assign push_err  = dec_err;
        assign push_data = dec_data;
    end else begin : g_pipe
        localparam int STAGES = LATENCY - 1;
        logic                  st_v_q    [STAGES];
        logic                  st_err_q  [STAGES];
        logic [DATA_WIDTH-1:0] st_data_q [STAGES];

        // Shift tokens one stage per cycle; reset drops everything in flight
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < STAGES; i++) begin
                    st_v_q[i]    <= 1'b0;
                    st_err_q[i]  <= 1'b0;
                    st_data_q[i] <= '0;
                end
            end else begin
                st_v_q[0]    <= gnt_o;
                st_err_q[0]  <= dec_err;
                st_data_q[0] <= dec_data;
                for (int i = 1; i < STAGES; i++) begin
                    st_v_q[i]    <= st_v_q[i-1];
                    st_err_q[i]  <= st_err_q[i-1];
                    st_data_q[i] <= st_data_q[i-1];
                end
            end
        end

        assign push_v    = st_v_q[STAGES-1];
        assign push_err  = st_err_q[STAGES-1];
        assign push_data = st_data_q[STAGES-1];
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for pointers, fill count and outstanding counter
    always_comb begin
        wr_ptr_d = push_v ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        outst_d  = outst_q;
        case ({push_v, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({gnt_o, pop})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Control state register; reset discards all buffered responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            outst_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
        end
    end

    // FIFO storage; contents only matter while covered by count_q
    logic [DATA_WIDTH-1:0] fifo_data_q [MAX_OUTST];
    logic                  fifo_err_q  [MAX_OUTST];

    // Write the arriving token at the tail
    always_ff @(posedge clk_i) begin
        if (push_v) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_err_q[wr_ptr_q]  <= push_err;
        end
    end

    assign rvalid_o = (count_q != '0);
    assign rdata_o  = rvalid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign err_o    = rvalid_o ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule
